// File: rtl/dct_mac_seq.sv
// dct_mac_seq -- control sequencer for one DCT unit's multiply-accumulate datapath.
//
// A start handshake launches one output coefficient. The sequencer steps TAPS
// sample/coefficient indices into the MAC and tags the first tap with an
// accumulator clear. It then waits out the multiplier and accumulator pipeline,
// pulses res_ld to capture the sum, and holds res_vld until downstream accepts.
// The MAC datapath has no control logic of its own; all of its timing comes from here.
//
// Parameters:
//   TAPS      taps per output coefficient (2..16)
//   MULT_LAT  cycles from mac_en until the accumulator holds that tap (1..7)
//   ROW       DCT row served by this unit; base of the coefficient ROM address
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ena        global clock enable; when low, all state and outputs hold
//   start      row request, held until start_ack
//   start_ack  one-cycle pulse when start is accepted
//   busy       high while taps are issued or the pipeline drains
//   tap_idx    sample select for the current tap
//   coef_addr  coefficient ROM address, ROW*TAPS + tap_idx
//   mac_en     MAC operands valid this cycle
//   mac_clr    with mac_en, the accumulator loads the product instead of adding it
//   res_ld     one-cycle pulse that captures the accumulator into the result register
//   res_vld    result register holds an unconsumed result
//   res_rdy    downstream accepts when res_vld && res_rdy && ena
//
// Optional build macro DCT_MAC_SEQ_STATS_EN adds:
//   stats_clr  synchronous clear of both statistics counters (takes priority)
//   row_cnt    saturating count of result handshakes
//   stall_cnt  saturating count of enabled DONE cycles with res_rdy low

module dct_mac_seq #(
    parameter int TAPS     = 8,
    parameter int MULT_LAT = 2,
    parameter int ROW      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           start,
    output logic                           start_ack,
    output logic                           busy,
    output logic [$clog2(TAPS)-1:0]        tap_idx,
    output logic [$clog2(TAPS*TAPS)-1:0]   coef_addr,
    output logic                           mac_en,
    output logic                           mac_clr,
    output logic                           res_ld,
    output logic                           res_vld,
    input  logic                           res_rdy
`ifdef DCT_MAC_SEQ_STATS_EN
    ,
    input  logic                           stats_clr,
    output logic [15:0]                    row_cnt,
    output logic [15:0]                    stall_cnt
`endif
);

    localparam int TW = $clog2(TAPS);
    localparam int AW = $clog2(TAPS*TAPS);
    localparam int DW = 3;

    localparam logic [TW-1:0] TAP_LAST  = TW'(TAPS - 1);
    localparam logic [AW-1:0] ROW_BASE  = AW'(ROW * TAPS);
    localparam logic [DW-1:0] DCNT_INIT = DW'(MULT_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   dcnt;
    logic            launch;

    // A new row may start from IDLE, or from DONE in the same cycle the current
    // result is accepted, so back-to-back rows have no bubble.
    always_comb begin
        launch = start && ((state == IDLE) || ((state == DONE) && res_rdy));
    end

    // Outputs are registered alongside the state, so each output reflects the
    // action of the state it sits in. res_ld is asserted in the DRAIN cycle
    // whose dcnt is zero; it is therefore set one edge ahead (on entry to DRAIN
    // when MULT_LAT is 1, otherwise when dcnt steps from 1 to 0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            start_ack <= 1'b0;
            busy      <= 1'b0;
            tap_idx   <= '0;
            coef_addr <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            res_ld    <= 1'b0;
            res_vld   <= 1'b0;
        end else if (ena) begin
            start_ack <= 1'b0;
            mac_clr   <= 1'b0;
            res_ld    <= 1'b0;

            if ((state == DONE) && res_rdy) begin
                res_vld <= 1'b0;
            end

            if (launch) begin
                state     <= ACCUM;
                start_ack <= 1'b1;
                busy      <= 1'b1;
                mac_en    <= 1'b1;
                mac_clr   <= 1'b1;
                tap_idx   <= '0;
                coef_addr <= ROW_BASE;
            end else begin
                case (state)
                    IDLE: ;
                    ACCUM: begin
                        if (tap_idx == TAP_LAST) begin
                            state     <= DRAIN;
                            mac_en    <= 1'b0;
                            tap_idx   <= '0;
                            coef_addr <= '0;
                            dcnt      <= DCNT_INIT;
                            res_ld    <= (DCNT_INIT == '0);
                        end else begin
                            tap_idx   <= tap_idx + TW'(1);
                            coef_addr <= coef_addr + AW'(1);
                        end
                    end
                    DRAIN: begin
                        if (dcnt == '0) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            res_vld <= 1'b1;
                        end else begin
                            dcnt   <= dcnt - DW'(1);
                            res_ld <= (dcnt == DW'(1));
                        end
                    end
                    DONE: begin
                        if (res_rdy) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DCT_MAC_SEQ_STATS_EN
    // Counters follow the global enable like all other state; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt   <= '0;
            stall_cnt <= '0;
        end else if (ena) begin
            if (stats_clr) begin
                row_cnt   <= '0;
                stall_cnt <= '0;
            end else begin
                if ((state == DONE) && res_rdy && (row_cnt != '1)) begin
                    row_cnt <= row_cnt + 16'd1;
                end
                if ((state == DONE) && !res_rdy && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dct_mac_seq.sv
// tb_dct_mac_seq -- self-checking bench for dct_mac_seq.
//
// A cycle table covers reset followed by a single row. Hand-written sequences
// cover back-to-back rows, backpressure, clock-enable gaps and reset during
// drain. A negedge monitor tracks tap order and coefficient addresses, and a
// queue holds the expected res_ld time for every accepted start.
// With DCT_MAC_SEQ_STATS_EN defined, the bench uses ROW=3 and also checks the
// statistics counters.

module tb_dct_mac_seq;

    localparam int TAPS     = 8;
    localparam int MULT_LAT = 2;
`ifdef DCT_MAC_SEQ_STATS_EN
    localparam int ROW      = 3;
`else
    localparam int ROW      = 0;
`endif
    localparam int TW = $clog2(TAPS);
    localparam int AW = $clog2(TAPS*TAPS);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic          res_rdy = 1'b0;
    logic          start_ack, busy, mac_en, mac_clr, res_ld, res_vld;
    logic [TW-1:0] tap_idx;
    logic [AW-1:0] coef_addr;
`ifdef DCT_MAC_SEQ_STATS_EN
    logic          stats_clr = 1'b0;
    logic [15:0]   row_cnt, stall_cnt;
`endif

    dct_mac_seq #(
        .TAPS     (TAPS),
        .MULT_LAT (MULT_LAT),
        .ROW      (ROW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .start_ack (start_ack),
        .busy      (busy),
        .tap_idx   (tap_idx),
        .coef_addr (coef_addr),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .res_ld    (res_ld),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy)
`ifdef DCT_MAC_SEQ_STATS_EN
        ,
        .stats_clr (stats_clr),
        .row_cnt   (row_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return start_ack;
            1:       return res_vld;
            default: return 1'b0;
        endcase
    endfunction

    // Call from a post-edge point; returns at the falling edge of the first cycle with the signal high.
    task automatic wait_sig(input string name, input int sel);
        bit hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            samp();
            if (sig(sel)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timed out waiting, got 0, expected 1", name);
        end
    endtask

    // ---------------- monitor and scoreboard ----------------
    int exp_tap = 0;
    int eff     = 0;
    int ld_q[$];
    int m_rows  = 0;
    int m_stalls = 0;

    always @(negedge clk) begin
        if (!rst) begin
            ld_q.delete();
            exp_tap  = 0;
            m_rows   = 0;
            m_stalls = 0;
        end else if (ena) begin
            if (mac_en) begin
                check("mon_tap_idx", 32'(tap_idx), 32'(exp_tap));
                check("mon_mac_clr", 32'(mac_clr), 32'(exp_tap == 0));
                check("mon_coef_addr", 32'(coef_addr), 32'(ROW * TAPS + exp_tap));
                exp_tap = (exp_tap == TAPS - 1) ? 0 : exp_tap + 1;
            end
            if (start_ack) begin
                ld_q.push_back(eff + TAPS + MULT_LAT - 1);
            end
            if (res_ld) begin
                check("ld_while_vld", 32'(res_vld), 32'd0);
                if (ld_q.size() == 0) begin
                    check("ld_unexpected", 32'd1, 32'd0);
                end else begin
                    check("sb_ld_latency", 32'(eff), 32'(ld_q.pop_front()));
                end
            end
`ifdef DCT_MAC_SEQ_STATS_EN
            if (stats_clr) begin
                m_rows   = 0;
                m_stalls = 0;
            end else begin
                if (res_vld && res_rdy)  m_rows++;
                if (res_vld && !res_rdy) m_stalls++;
            end
`endif
            eff++;
        end
    end

    // ---------------- single-row cycle table ----------------
    typedef struct {
        logic start;
        logic rdy;
        logic ack;
        logic en;
        logic clr;
        logic ld;
        logic vld;
        logic bsy;
        int   tap;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic s, input logic r, input logic a, input logic e,
                                input logic c, input logic l, input logic v, input logic b,
                                input int t);
        vec_t x;
        x.start = s; x.rdy = r; x.ack = a; x.en = e; x.clr = c;
        x.ld = l; x.vld = v; x.bsy = b; x.tap = t;
        return x;
    endfunction

    initial begin
        int a0;

        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 1, 0, 0, 1, 0);
        for (int i = 2; i <= 8; i++) tbl[i] = mk(0, 1, 0, 1, 0, 0, 0, 1, i - 1);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, 0, 0, 1, 0, 1, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) samp();
        check("rst_start_ack", 32'(start_ack), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_tap_idx",   32'(tap_idx), 0);
        check("rst_coef_addr", 32'(coef_addr), 0);
        check("rst_mac_en",    32'(mac_en), 0);
        check("rst_mac_clr",   32'(mac_clr), 0);
        check("rst_res_ld",    32'(res_ld), 0);
        check("rst_res_vld",   32'(res_vld), 0);
`ifdef DCT_MAC_SEQ_STATS_EN
        check("rst_row_cnt",   32'(row_cnt), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
        tick();
        rst = 1'b1;

        // Single row, cycle by cycle
        for (int i = 0; i < 13; i++) begin
            start   = tbl[i].start;
            res_rdy = tbl[i].rdy;
            samp();
            check($sformatf("tbl%0d_start_ack", i), 32'(start_ack), 32'(tbl[i].ack));
            check($sformatf("tbl%0d_mac_en", i),    32'(mac_en),    32'(tbl[i].en));
            check($sformatf("tbl%0d_mac_clr", i),   32'(mac_clr),   32'(tbl[i].clr));
            check($sformatf("tbl%0d_res_ld", i),    32'(res_ld),    32'(tbl[i].ld));
            check($sformatf("tbl%0d_res_vld", i),   32'(res_vld),   32'(tbl[i].vld));
            check($sformatf("tbl%0d_busy", i),      32'(busy),      32'(tbl[i].bsy));
            if (tbl[i].en) begin
                check($sformatf("tbl%0d_tap_idx", i),   32'(tap_idx),   32'(tbl[i].tap));
                check($sformatf("tbl%0d_coef_addr", i), 32'(coef_addr), 32'(ROW * TAPS + tbl[i].tap));
            end
            tick();
        end

        // Back-to-back rows: start held through the first handshake
        start   = 1'b1;
        res_rdy = 1'b1;
        wait_sig("b2b_first_vld", 1);
        check("b2b_ack_pending", 32'(start_ack), 0);
        tick();
        start = 1'b0;
        samp();
        check("b2b_second_ack", 32'(start_ack), 1);
        check("b2b_second_clr", 32'(mac_clr), 1);
        check("b2b_second_en",  32'(mac_en), 1);
        check("b2b_vld_dropped", 32'(res_vld), 0);
        tick();
        wait_sig("b2b_second_vld", 1);
        tick();
        samp();
        check("b2b_idle_vld",  32'(res_vld), 0);
        check("b2b_idle_busy", 32'(busy), 0);
        tick();

        // Backpressure: five stalled DONE cycles with a new start pending
        start   = 1'b1;
        res_rdy = 1'b0;
        wait_sig("bp_vld", 1);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("bp%0d_res_vld", j),   32'(res_vld), 1);
            check($sformatf("bp%0d_res_ld", j),    32'(res_ld), 0);
            check($sformatf("bp%0d_start_ack", j), 32'(start_ack), 0);
            tick();
            if (j < 4) samp();
        end
        res_rdy = 1'b1;
        samp();
        check("bp_hs_vld", 32'(res_vld), 1);
        tick();
        samp();
        check("bp_next_ack", 32'(start_ack), 1);
        check("bp_next_clr", 32'(mac_clr), 1);
        tick();
        start = 1'b0;
        wait_sig("bp_second_vld", 1);
        tick();

        // Enable gap: three disabled cycles while tap 4 is presented
        start = 1'b1;
        wait_sig("gap_ack", 0);
        a0 = cyc;
        tick();
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            samp();
            if (mac_en && tap_idx == TW'(3)) break;
            tick();
        end
        check("gap_reached_tap3", 32'(tap_idx), 3);
        tick();
        ena = 1'b0;
        for (int j = 0; j < 3; j++) begin
            samp();
            check($sformatf("gap%0d_tap_hold", j), 32'(tap_idx), 4);
            check($sformatf("gap%0d_en_hold", j),  32'(mac_en), 1);
            tick();
        end
        ena = 1'b1;
        samp();
        check("gap_resume_tap", 32'(tap_idx), 4);
        tick();
        wait_sig("gap_vld", 1);
        check("gap_latency", 32'(cyc - a0), 32'(TAPS + MULT_LAT + 3));
        tick();

        // Reset during drain, then a fresh row
        start = 1'b1;
        wait_sig("rd_ack", 0);
        tick();
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            samp();
            if (busy && !mac_en) break;
            tick();
        end
        check("rd_in_drain", 32'(busy && !mac_en), 1);
        tick();
        rst = 1'b0;
        samp();
        check("rd_start_ack", 32'(start_ack), 0);
        check("rd_busy",      32'(busy), 0);
        check("rd_tap_idx",   32'(tap_idx), 0);
        check("rd_coef_addr", 32'(coef_addr), 0);
        check("rd_mac_en",    32'(mac_en), 0);
        check("rd_mac_clr",   32'(mac_clr), 0);
        check("rd_res_ld",    32'(res_ld), 0);
        check("rd_res_vld",   32'(res_vld), 0);
        tick();
        rst = 1'b1;
        samp();
        check("rd_idle_busy",  32'(busy), 0);
        check("rd_idle_res_ld", 32'(res_ld), 0);
        tick();
        start = 1'b1;
        wait_sig("rd_new_ack", 0);
        check("rd_new_clr", 32'(mac_clr), 1);
        check("rd_new_tap", 32'(tap_idx), 0);
        tick();
        start = 1'b0;
        wait_sig("rd_new_vld", 1);
        tick();

`ifdef DCT_MAC_SEQ_STATS_EN
        // Statistics: clear, three rows with two stall cycles, clear again
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        samp();
        check("st_clr0_rows",   32'(row_cnt), 0);
        check("st_clr0_stalls", 32'(stall_cnt), 0);
        tick();
        for (int r = 0; r < 3; r++) begin
            start   = 1'b1;
            res_rdy = (r != 0);
            wait_sig("st_ack", 0);
            tick();
            start = 1'b0;
            wait_sig("st_vld", 1);
            if (r == 0) begin
                tick();
                tick();
                res_rdy = 1'b1;
            end
            tick();
        end
        samp();
        check("st_row_cnt",   32'(row_cnt), 3);
        check("st_stall_cnt", 32'(stall_cnt), 2);
        check("st_model_rows",   32'(row_cnt), 32'(m_rows));
        check("st_model_stalls", 32'(stall_cnt), 32'(m_stalls));
        tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        samp();
        check("st_clr1_rows",   32'(row_cnt), 0);
        check("st_clr1_stalls", 32'(stall_cnt), 0);
        tick();
`endif

        repeat (3) tick();
        samp();
        check("end_queue_empty", 32'(ld_q.size()), 0);
        check("end_tap_complete", 32'(exp_tap), 0);
        check("end_idle_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
